step_driver: RTL and testbench
==============================

Name: step_driver

Overview:
- Transmit end of the up/down strobe interface used by the team's up/down counters.
- Accepts a target count over a valid/ready handshake.
- Emits single-cycle up_o/down_o strobes at a programmable rate until its internal mirror of the downstream count equals the target.
- Used to walk window and ROI coordinate counters in the vision pipeline to new positions at a controlled step rate.

Parameters:
- width_p, 8: width of target, position and mirrored count.
- period_width_p, 8: width of the step-period field.
- reset_val_p, 0 (width_p bits): position after reset; must match the downstream counter's reset value.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_i  input  1  synchronous reset, active-low (0 = reset).
- target_i  input  width_p  requested final count.
- period_i  input  period_width_p  cycles between strobes; 0 is treated as 1.
- valid_i  input  1  target_i/period_i valid.
- ready_o  output  1  block can accept a request.
- abort_i  input  1  stop the current move.
- up_o  output  1  one-cycle increment strobe to the counter.
- down_o  output  1  one-cycle decrement strobe to the counter.
- position_o  output  width_p  mirrored count, equal to the downstream counter output.
- busy_o  output  1  high in STEP.
- done_o  output  1  one-cycle pulse when a move completes.

Behaviour:
- Reset (reset_i=0 at a posedge):
  - State IDLE; position_o=reset_val_p; divider=0; done_o=0.
  - up_o, down_o and busy_o are forced 0 combinationally while reset_i=0.
  - Reset mid-move discards the move; no done_o.
- States:
  - IDLE: ready_o=1, busy_o=0.
  - STEP: ready_o=0, busy_o=1.
- Accept (IDLE, valid_i & ready_o at an edge):
  - Latch target and P = max(period_i,1).
  - Load divider with P-1.
  - Latch direction: up if target > position (unsigned), else down.
  - If target == position, stay IDLE and pulse done_o in the next cycle; no strobes.
  - Otherwise go to STEP.
- STEP, each cycle:
  - Strobe condition: divider == 0 and abort_i == 0. Assert up_o or down_o combinationally from registered state.
  - At the edge of a strobe cycle, position increments or decrements by 1 and the divider reloads P-1. Otherwise the divider decrements.
  - First strobe appears P cycles after the accept edge. Later strobes are spaced exactly P cycles.
  - Only up_o or down_o is high at a time; never both.
  - When a strobe makes position equal to target, go to IDLE. done_o is high in the following cycle, and ready_o is high in that same cycle.
- Abort:
  - abort_i=1 in STEP suppresses that cycle's strobe and returns to IDLE.
  - position keeps its value; done_o is not pulsed.
  - abort_i is ignored in IDLE.
- Arithmetic:
  - position moves monotonically toward target and never wraps (e.g. 0→255 takes 255 up strobes, not 1 down).
  - Divider is period_width_p bits.
- Invariant: position_o equals the value a counter driven by up_o/down_o (same reset_val_p, same reset) holds.
- valid_i high while in STEP is ignored (ready_o=0) unless the optional feature is compiled in.

Optional Feature:
- Macro: STEP_DRIVER_RETARGET_EN.
- Defined:
  - ready_o=1 in STEP as well.
  - An accept in STEP replaces target and P, and recomputes direction against the current position. Position here is post-strobe if the same edge strobes.
  - Divider reloads P-1; no strobe is lost or duplicated.
  - If the new target equals the updated position, go to IDLE and pulse done_o in the next cycle.
  - abort_i has priority over an accept in the same cycle.
- Undefined: ready_o = (state == IDLE) as above.

Test Plan:
- Reset: hold reset_i=0 for 3 cycles with reset_val_p=5 → position_o=5, ready_o=1, up_o=down_o=0 throughout.
- Up move: position 5, target 8, period 3 → up_o high at cycles 3, 6, 9 after accept; position_o 6, 7, 8; done_o in cycle 10; a reference counter ends at 8.
- Down move, period 0: position 8, target 4 → down_o high 4 consecutive cycles starting the cycle after accept; done_o next; position_o=4.
- Null move: target == position (4) → no strobes, done_o the cycle after accept, state stays IDLE.
- Abort: target 20 from 4, period 2, abort_i pulsed after 3 strobes → position_o=7, no further strobes, no done_o, ready_o=1 next cycle.
- Reset mid-move plus retarget (with STEP_DRIVER_RETARGET_EN):
  - Retarget from 10 to 6 while at position 8 → down strobes to 6, done_o once.
  - reset_i=0 mid-move → position_o=reset_val_p and no done_o.

Source files
------------

// File: rtl/step_driver.sv
// step_driver: transmit end of the up/down strobe interface used by the
// up/down counters.
//
// A move request (target_i, period_i) is accepted over a valid/ready
// handshake. The block then emits single-cycle up_o/down_o strobes, one
// every max(period_i,1) cycles, until its internal mirror of the downstream
// count (position_o) equals the target. done_o pulses for one cycle when a
// move completes. abort_i stops a move without a done pulse.
//
// Optional build macro: STEP_DRIVER_RETARGET_EN
//   When defined, ready_o stays high in STEP and an accepted request
//   replaces the move in flight. The new direction is computed against the
//   post-strobe position. An abort in the same cycle wins over the accept.
//
// Ports:
//   clk_i       clock, all state updates on posedge
//   reset_i     synchronous reset, active-low
//   target_i    requested final count
//   period_i    cycles between strobes (0 behaves as 1)
//   valid_i     target_i/period_i valid
//   ready_o     request can be accepted
//   abort_i     stop the current move
//   up_o        one-cycle increment strobe
//   down_o      one-cycle decrement strobe
//   position_o  mirrored downstream count
//   busy_o      high while stepping
//   done_o      one-cycle pulse when a move completes
module step_driver #(
  parameter int unsigned         width_p        = 8,
  parameter int unsigned         period_width_p = 8,
  parameter logic [width_p-1:0]  reset_val_p    = '0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [width_p-1:0]        target_i,
  input  logic [period_width_p-1:0] period_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      abort_i,
  output logic                      up_o,
  output logic                      down_o,
  output logic [width_p-1:0]        position_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [width_p-1:0]        position_q, position_d;
  logic [width_p-1:0]        target_q, target_d;
  logic [period_width_p-1:0] reload_q, reload_d;
  logic [period_width_p-1:0] divider_q, divider_d;
  logic                      dir_up_q, dir_up_d;
  logic                      done_q, done_d;

  logic                      strobe;
  logic                      accept;
  logic [width_p-1:0]        pos_stepped;

  // Divider reload value P-1 with P = max(period,1).
  function automatic logic [period_width_p-1:0] reload_of(
    input logic [period_width_p-1:0] p
  );
    return (p == '0) ? '0 : p - period_width_p'(1);
  endfunction

  // Strobes come straight from registered state so the downstream counter
  // sees them in the same cycle; reset forces them low immediately.
  assign strobe      = reset_i && (state_q == STEP) && (divider_q == '0) && !abort_i;
  assign up_o        = strobe & dir_up_q;
  assign down_o      = strobe & ~dir_up_q;
  assign busy_o      = reset_i && (state_q == STEP);
  assign position_o  = position_q;
  assign done_o      = done_q;
  assign pos_stepped = dir_up_q ? position_q + width_p'(1) : position_q - width_p'(1);

`ifdef STEP_DRIVER_RETARGET_EN
  assign ready_o = 1'b1;
`else
  assign ready_o = (state_q == IDLE);
`endif

  // An abort while stepping takes priority over any request in that cycle.
  assign accept = valid_i && ready_o && !((state_q == STEP) && abort_i);

  always_comb begin
    state_d    = state_q;
    position_d = position_q;
    target_d   = target_q;
    reload_d   = reload_q;
    divider_d  = divider_q;
    dir_up_d   = dir_up_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d  = target_i;
          reload_d  = reload_of(period_i);
          divider_d = reload_of(period_i);
          dir_up_d  = (target_i > position_q);
          if (target_i == position_q) begin
            done_d = 1'b1;
          end else begin
            state_d = STEP;
          end
        end
      end

      STEP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          if (strobe) begin
            position_d = pos_stepped;
            divider_d  = reload_q;
            if (pos_stepped == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            divider_d = divider_q - period_width_p'(1);
          end
`ifdef STEP_DRIVER_RETARGET_EN
          // A new request overrides the move, judged against the position
          // this edge leaves behind (post-strobe if it strobes).
          if (accept) begin
            target_d  = target_i;
            reload_d  = reload_of(period_i);
            divider_d = reload_of(period_i);
            dir_up_d  = (target_i > position_d);
            if (target_i == position_d) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = STEP;
              done_d  = 1'b0;
            end
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      position_q <= reset_val_p;
      divider_q  <= '0;
      dir_up_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      position_q <= position_d;
      divider_q  <= divider_d;
      dir_up_q   <= dir_up_d;
      done_q     <= done_d;
    end
  end

  // Request payload only matters once a move is accepted.
  always_ff @(posedge clk_i) begin
    target_q <= target_d;
    reload_q <= reload_d;
  end

endmodule

// File: tb/tb_step_driver.sv
// Testbench for step_driver (reset_val_p = 5). A per-cycle vector table
// covers reset, up move, down move with period 0, null move and abort; hand
// sequences cover reset mid-move and (when STEP_DRIVER_RETARGET_EN is
// defined) retargeting. A reference up/down counter tracks the strobes.
module tb_step_driver;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] target_i;
  logic [7:0] period_i;
  logic       valid_i;
  logic       ready_o;
  logic       abort_i;
  logic       up_o;
  logic       down_o;
  logic [7:0] position_o;
  logic       busy_o;
  logic       done_o;

  logic [7:0] ref_cnt;
  int         total  = 0;
  int         passed = 0;

`ifdef STEP_DRIVER_RETARGET_EN
  localparam bit RETARGET = 1'b1;
`else
  localparam bit RETARGET = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  step_driver #(
    .width_p        (8),
    .period_width_p (8),
    .reset_val_p    (8'd5)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .target_i   (target_i),
    .period_i   (period_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .abort_i    (abort_i),
    .up_o       (up_o),
    .down_o     (down_o),
    .position_o (position_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  // Reference counter driven only by the strobes.
  always @(posedge clk_i) begin
    if (!reset_i)    ref_cnt <= 8'd5;
    else if (up_o)   ref_cnt <= ref_cnt + 8'd1;
    else if (down_o) ref_cnt <= ref_cnt - 8'd1;
  end

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] tgt;
    logic [7:0] per;
    logic       abt;
    logic       up;
    logic       dn;
    logic       rdy;
    logic       bsy;
    logic       dne;
    logic [7:0] pos;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic vld, input logic [7:0] tgt,
                     input logic [7:0] per, input logic abt, input logic up,
                     input logic dn, input logic rdy, input logic bsy,
                     input logic dne, input logic [7:0] pos);
    vec_t v;
    v.rst = rst; v.vld = vld; v.tgt = tgt; v.per = per; v.abt = abt;
    v.up = up; v.dn = dn; v.rdy = rdy; v.bsy = bsy; v.dne = dne; v.pos = pos;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  int dones;

  initial begin
    reset_i = 1'b0; valid_i = 1'b0; abort_i = 1'b0;
    target_i = '0;  period_i = '0;

    //   rst vld tgt per abt  up dn rdy bsy dne pos
    add(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 5);   // reset held
    add(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 5);
    add(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 5);
    add(1, 1, 8,  3, 0,  0, 0, 1, 0, 0, 5);   // accept 5 -> 8, P=3
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 5);   // c1
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 5);   // c2
    add(1, 0, 0,  0, 0,  1, 0, 0, 1, 0, 5);   // c3 strobe
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 6);
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 6);
    add(1, 0, 0,  0, 0,  1, 0, 0, 1, 0, 6);   // c6 strobe
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 7);
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 7);
    add(1, 0, 0,  0, 0,  1, 0, 0, 1, 0, 7);   // c9 strobe
    add(1, 1, 4,  0, 0,  0, 0, 1, 0, 1, 8);   // c10 done; accept 8 -> 4, P=0
    add(1, 0, 0,  0, 0,  0, 1, 0, 1, 0, 8);
    add(1, 0, 0,  0, 0,  0, 1, 0, 1, 0, 7);
    add(1, 0, 0,  0, 0,  0, 1, 0, 1, 0, 6);
    add(1, 0, 0,  0, 0,  0, 1, 0, 1, 0, 5);
    add(1, 1, 4,  5, 0,  0, 0, 1, 0, 1, 4);   // done; null move accept
    add(1, 0, 0,  0, 0,  0, 0, 1, 0, 1, 4);   // null-move done, still IDLE
    add(1, 1, 20, 2, 0,  0, 0, 1, 0, 0, 4);   // accept 4 -> 20, P=2
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 4);
    add(1, 0, 0,  0, 0,  1, 0, 0, 1, 0, 4);
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 5);
    add(1, 0, 0,  0, 0,  1, 0, 0, 1, 0, 5);
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 6);
    add(1, 0, 0,  0, 0,  1, 0, 0, 1, 0, 6);   // third strobe
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 7);
    add(1, 0, 0,  0, 1,  0, 0, 0, 1, 0, 7);   // abort on a strobe cycle
    add(1, 0, 0,  0, 0,  0, 0, 1, 0, 0, 7);   // IDLE, no done
    add(1, 0, 0,  0, 1,  0, 0, 1, 0, 0, 7);   // abort ignored in IDLE

    next_cycle();
    foreach (tbl[i]) begin
      reset_i  = tbl[i].rst;
      valid_i  = tbl[i].vld;
      target_i = tbl[i].tgt;
      period_i = tbl[i].per;
      abort_i  = tbl[i].abt;
      @(negedge clk_i);
      chk("up",    i, up_o,       tbl[i].up);
      chk("down",  i, down_o,     tbl[i].dn);
      chk("ready", i, ready_o,    RETARGET ? 1'b1 : tbl[i].rdy);
      chk("busy",  i, busy_o,     tbl[i].bsy);
      chk("done",  i, done_o,     tbl[i].dne);
      chk("pos",   i, position_o, tbl[i].pos);
      chk("refcnt", i, ref_cnt,   position_o);
      next_cycle();
    end

    // Reset in the middle of a move: 7 -> 10 at one strobe per cycle.
    abort_i = 1'b0; valid_i = 1'b1; target_i = 8'd10; period_i = 8'd1;
    next_cycle();
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_up", 0, up_o, 1'b1);
    chk("mid_pos", 0, position_o, 8'd7);
    next_cycle();
    @(negedge clk_i);
    chk("mid_up", 1, up_o, 1'b1);
    chk("mid_pos", 1, position_o, 8'd8);
    next_cycle();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_up_forced", 0, up_o, 1'b0);
    chk("rst_busy_forced", 0, busy_o, 1'b0);
    next_cycle();
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("rst_pos", 0, position_o, 8'd5);
    chk("rst_ready", 0, ready_o, 1'b1);
    chk("rst_busy", 0, busy_o, 1'b0);
    chk("rst_ref", 0, ref_cnt, position_o);
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      if (done_o === 1'b1 || up_o === 1'b1 || down_o === 1'b1) dones++;
      next_cycle();
      @(negedge clk_i);
    end
    chk("rst_no_done_or_strobe", 0, dones, 0);

`ifdef STEP_DRIVER_RETARGET_EN
    // Retarget: 5 -> 10 at P=2, then 6 at P=1 while at position 8.
    next_cycle();
    valid_i = 1'b1; target_i = 8'd10; period_i = 8'd2;
    next_cycle();
    valid_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      chk("rt_up", c, up_o, (c % 2 == 0) ? 1'b1 : 1'b0);
      next_cycle();
    end
    valid_i = 1'b1; target_i = 8'd6; period_i = 8'd1;
    @(negedge clk_i);
    chk("rt_pos8", 0, position_o, 8'd8);
    chk("rt_nostrobe", 0, up_o | down_o, 1'b0);
    next_cycle();
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("rt_down", 0, down_o, 1'b1);
    chk("rt_pos", 0, position_o, 8'd8);
    next_cycle();
    @(negedge clk_i);
    chk("rt_down", 1, down_o, 1'b1);
    chk("rt_pos", 1, position_o, 8'd7);
    next_cycle();
    @(negedge clk_i);
    chk("rt_pos_final", 0, position_o, 8'd6);
    chk("rt_busy", 0, busy_o, 1'b0);
    chk("rt_ref", 0, ref_cnt, position_o);
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      if (done_o === 1'b1) dones++;
      next_cycle();
      @(negedge clk_i);
    end
    chk("rt_done_once", 0, dones, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
